// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
//
// Measures the spacing, in clk cycles, between rising edges of pulse_in.
// Each rising edge closes one measurement. The first edge after reset or
// timeout only arms the counter. Results go out on a valid/ready port.
// Overwriting an unconsumed result raises overrun. A gap longer than
// MAX_PERIOD raises timeout and drops lock.
//
// Parameters:
//   MAX_PERIOD  longest measurable period in clk cycles (>= 2)
//   N           counter/result width, $clog2(MAX_PERIOD+1)
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   pulse_in  pulse train to measure; only rising edges count
//   period    last measured period (registered)
//   valid     period holds an unconsumed measurement
//   ready     consumer accepts period when valid && ready
//   overrun   one-cycle pulse: an unconsumed measurement was overwritten
//   timeout   one-cycle pulse: no edge within MAX_PERIOD cycles
//   locked    at least one measurement since the last reset or timeout
//
// Build option:
//   PERIOD_METER_SYNC_EN  when defined, pulse_in passes through a two-flop
//                         synchronizer first (adds 2 cycles of latency,
//                         measured periods unchanged). When undefined,
//                         pulse_in must be synchronous to clk.
// ---------------------------------------------------------------------------
module period_meter #(
    parameter int MAX_PERIOD = 12_000_000,
    localparam int N = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pulse_in,
    output logic [N-1:0] period,
    output logic         valid,
    input  logic         ready,
    output logic         overrun,
    output logic         timeout,
    output logic         locked
);

    localparam logic [N-1:0] MAX_CNT = N'(MAX_PERIOD);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] cnt, cnt_nxt;
    logic [N-1:0] period_nxt;
    logic         valid_nxt;
    logic         overrun_nxt;
    logic         timeout_nxt;
    logic         locked_nxt;
    logic         load;

    logic         s;
    logic         s_prev;
    logic         edge_det;

`ifdef PERIOD_METER_SYNC_EN
    logic         sync_p0;
    logic         sync_p1;

    // Stage p0 -> p1: two-flop synchronizer. Both flops reset high so that
    // an input already high at reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= pulse_in;
            sync_p1 <= sync_p0;
        end
    end

    assign s = sync_p1;
`else
    assign s = pulse_in;
`endif

    // prev resets high: a level already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev <= 1'b1;
        end else begin
            s_prev <= s;
        end
    end

    assign edge_det = s & ~s_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            period  <= period_nxt;
            valid   <= valid_nxt;
            overrun <= overrun_nxt;
            timeout <= timeout_nxt;
            locked  <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load        = 1'b0;
        timeout_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (edge_det) begin
                    // First edge only arms; counting starts at 1 so that a
                    // tick every P cycles later reads exactly P.
                    cnt_nxt   = N'(1);
                    state_nxt = MEASURE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            MEASURE: begin
                // An edge at cnt == MAX_CNT is still a valid measurement,
                // so the edge test takes priority over the timeout test.
                if (edge_det) begin
                    load    = 1'b1;
                    cnt_nxt = N'(1);
                end else if (cnt == MAX_CNT) begin
                    timeout_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + N'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        period_nxt = load ? cnt : period;

        // A load wins over a same-cycle accept: the old value is consumed
        // and the new one is presented, so valid stays high.
        if (load) begin
            valid_nxt = 1'b1;
        end else if (valid && ready) begin
            valid_nxt = 1'b0;
        end else begin
            valid_nxt = valid;
        end

        overrun_nxt = load & valid & ~ready;

        if (load) begin
            locked_nxt = 1'b1;
        end else if (timeout_nxt) begin
            locked_nxt = 1'b0;
        end else begin
            locked_nxt = locked;
        end
    end

endmodule
